// File: rtl/dc_frame_router_if.sv
// FIFO head-word handshake between a first-word-fall-through FIFO and the router.
// Signals: i_fifo_data (head word), i_fifo_empty (empty flag), o_fifo_rd (dequeue strobe).
interface dc_frame_router_if;
    logic [31:0] i_fifo_data;
    logic        i_fifo_empty;
    logic        o_fifo_rd;

    modport master (
        output i_fifo_data,
        output i_fifo_empty,
        input  o_fifo_rd
    );

    modport slave (
        input  i_fifo_data,
        input  i_fifo_empty,
        output o_fifo_rd
    );
endinterface

// File: rtl/dc_frame_router.sv
// Routes DC payload frames and launch commands from a FWFT FIFO stream.
// Ports: i_clk, i_rst (async active-high), fifo (slave modport),
//   o_dc_regs/o_channel_sel/o_frame_valid/o_frame_cnt (DC commits),
//   o_launch_cmd/o_launch_valid (launch commits), o_err_hdr/o_err_timeout,
//   o_busy. Define DC_ROUTER_CKSUM_EN to require a trailing XOR checksum
//   word on DC packets (adds CHECK state and o_err_cksum).
module dc_frame_router #(
    parameter int N_CHANNELS     = 24,
    parameter int PAYLOAD_WORDS  = 61,
    parameter int LAUNCH_WORDS   = 4,
    parameter int TIMEOUT_CYCLES = 1023,
    localparam int CW = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    dc_frame_router_if.slave               fifo,
    output logic [PAYLOAD_WORDS-1:0][31:0] o_dc_regs,
    output logic [CW-1:0]                  o_channel_sel,
    output logic                           o_frame_valid,
    output logic [LAUNCH_WORDS-1:0][31:0]  o_launch_cmd,
    output logic                           o_launch_valid,
    output logic                           o_err_hdr,
    output logic                           o_err_timeout,
`ifdef DC_ROUTER_CKSUM_EN
    output logic                           o_err_cksum,
`endif
    output logic [15:0]                    o_frame_cnt,
    output logic                           o_busy
);

    localparam int MAXW = (PAYLOAD_WORDS > LAUNCH_WORDS) ?
                          PAYLOAD_WORDS : LAUNCH_WORDS;
    localparam int CNTW = $clog2(MAXW + 1);
    localparam int TW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    // Channel field stops at bit 31 for wide configurations.
    localparam int FTOP = (N_CHANNELS + 8 < 32) ? N_CHANNELS + 8 : 32;

    localparam logic [CNTW-1:0] PL_LAST  = CNTW'(PAYLOAD_WORDS - 1);
    localparam logic [CNTW-1:0] LN_LAST  = CNTW'(LAUNCH_WORDS - 1);
    localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        PAYLOAD,
        LAUNCH
`ifdef DC_ROUTER_CKSUM_EN
        , CHECK
`endif
    } state_t;

    state_t state, state_n;

    logic [31:0] d;
    logic        take;
    logic [CNTW-1:0] cnt;
    logic [TW-1:0]   tcnt;
    logic        tmo_hit;

    logic [PAYLOAD_WORDS-1:0][31:0] dc_sh;
    logic [LAUNCH_WORDS-1:0][31:0]  ln_sh;
    logic [CW-1:0] ch_q;

    logic [4:0]    n_zero;
    logic          upper_ok;
    logic          hdr_ok;
    logic [CW-1:0] hdr_ch;

    logic go_pl, go_ln, c_dc, c_ln, e_hdr, e_tmo;
`ifdef DC_ROUTER_CKSUM_EN
    logic [31:0] acc;
    logic        e_cks;
`endif

    assign d              = fifo.i_fifo_data;
    assign take           = !fifo.i_fifo_empty;
    assign fifo.o_fifo_rd = !fifo.i_fifo_empty;
    assign o_busy         = (state != IDLE);
    assign tmo_hit        = (tcnt == TMO_LAST);

    // Header: exactly one zero in the channel field, all ones above it.
    always_comb begin
        n_zero   = '0;
        upper_ok = 1'b1;
        hdr_ch   = '0;
        for (int i = 8; i < 32; i++) begin
            if (i < FTOP) begin
                if (!d[i]) begin
                    n_zero = n_zero + 5'd1;
                    hdr_ch = CW'(i - 8);
                end
            end else if (!d[i]) begin
                upper_ok = 1'b0;
            end
        end
        hdr_ok = upper_ok && (n_zero == 5'd1);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        go_pl   = 1'b0;
        go_ln   = 1'b0;
        c_dc    = 1'b0;
        c_ln    = 1'b0;
        e_hdr   = 1'b0;
        e_tmo   = 1'b0;
`ifdef DC_ROUTER_CKSUM_EN
        e_cks   = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (take) begin
                    if (d == 32'hFFFF_FFFF) begin
                        go_ln   = 1'b1;
                        state_n = LAUNCH;
                    end else if (hdr_ok) begin
                        go_pl   = 1'b1;
                        state_n = PAYLOAD;
                    end else begin
                        e_hdr   = 1'b1;
                    end
                end
            end
            PAYLOAD: begin
                if (take) begin
                    if (cnt == PL_LAST) begin
`ifdef DC_ROUTER_CKSUM_EN
                        state_n = CHECK;
`else
                        c_dc    = 1'b1;
                        state_n = IDLE;
`endif
                    end
                end else if (tmo_hit) begin
                    e_tmo   = 1'b1;
                    state_n = IDLE;
                end
            end
            LAUNCH: begin
                if (take) begin
                    if (cnt == LN_LAST) begin
                        c_ln    = 1'b1;
                        state_n = IDLE;
                    end
                end else if (tmo_hit) begin
                    e_tmo   = 1'b1;
                    state_n = IDLE;
                end
            end
`ifdef DC_ROUTER_CKSUM_EN
            CHECK: begin
                if (take) begin
                    state_n = IDLE;
                    if (d == acc) c_dc  = 1'b1;
                    else          e_cks = 1'b1;
                end else if (tmo_hit) begin
                    e_tmo   = 1'b1;
                    state_n = IDLE;
                end
            end
`endif
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt            <= '0;
            tcnt           <= '0;
            dc_sh          <= '0;
            ln_sh          <= '0;
            ch_q           <= '0;
            o_dc_regs      <= '0;
            o_launch_cmd   <= '0;
            o_channel_sel  <= '0;
            o_frame_cnt    <= '0;
            o_frame_valid  <= 1'b0;
            o_launch_valid <= 1'b0;
            o_err_hdr      <= 1'b0;
            o_err_timeout  <= 1'b0;
`ifdef DC_ROUTER_CKSUM_EN
            acc            <= '0;
            o_err_cksum    <= 1'b0;
`endif
        end else begin
            o_frame_valid  <= c_dc;
            o_launch_valid <= c_ln;
            o_err_hdr      <= e_hdr;
            o_err_timeout  <= e_tmo;
`ifdef DC_ROUTER_CKSUM_EN
            o_err_cksum    <= e_cks;
`endif

            if (go_pl || go_ln)             cnt <= '0;
            else if (take && state != IDLE) cnt <= cnt + 1'b1;

            if (state == IDLE || take) tcnt <= '0;
            else                       tcnt <= tcnt + 1'b1;

            if (go_pl) ch_q <= hdr_ch;

            if (state == PAYLOAD && take) begin
                for (int j = 0; j < PAYLOAD_WORDS; j++)
                    if (cnt == CNTW'(j)) dc_sh[j] <= d;
            end

            if (state == LAUNCH && take) begin
                for (int j = 0; j < LAUNCH_WORDS; j++)
                    if (cnt == CNTW'(j)) ln_sh[j] <= d;
            end

`ifdef DC_ROUTER_CKSUM_EN
            if (go_pl)                         acc <= d;
            else if (state == PAYLOAD && take) acc <= acc ^ d;
`endif

            // The last word lands in the shadow on this same edge, so the
            // commit takes it straight from the FIFO head.
            if (c_dc) begin
                for (int j = 0; j < PAYLOAD_WORDS; j++) begin
`ifdef DC_ROUTER_CKSUM_EN
                    o_dc_regs[j] <= dc_sh[j];
`else
                    o_dc_regs[j] <= (j == PAYLOAD_WORDS - 1) ? d : dc_sh[j];
`endif
                end
                o_channel_sel <= ch_q;
                o_frame_cnt   <= o_frame_cnt + 16'd1;
            end

            if (c_ln) begin
                for (int j = 0; j < LAUNCH_WORDS; j++)
                    o_launch_cmd[j] <= (j == LAUNCH_WORDS - 1) ? d : ln_sh[j];
            end
        end
    end

endmodule

// File: tb/tb_dc_frame_router.sv
// Self-checking bench for dc_frame_router: packet-level stream model plus
// directed frames, launches, header errors, timeout and mid-packet reset.
module tb_dc_frame_router;

    localparam int NCH = 24;
    localparam int PW  = 61;
    localparam int LW  = 4;
    localparam int TO  = 1023;
`ifdef DC_ROUTER_CKSUM_EN
    localparam int CK  = 1;
`else
    localparam int CK  = 0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic [31:0] fd;
    logic fe;

    logic [PW-1:0][31:0] o_dc_regs;
    logic [4:0]          o_channel_sel;
    logic                o_frame_valid;
    logic [LW-1:0][31:0] o_launch_cmd;
    logic                o_launch_valid;
    logic                o_err_hdr;
    logic                o_err_timeout;
    logic [15:0]         o_frame_cnt;
    logic                o_busy;
`ifdef DC_ROUTER_CKSUM_EN
    logic                o_err_cksum;
`endif

    dc_frame_router_if fif ();
    assign fif.i_fifo_data  = fd;
    assign fif.i_fifo_empty = fe;

    dc_frame_router #(
        .N_CHANNELS(NCH),
        .PAYLOAD_WORDS(PW),
        .LAUNCH_WORDS(LW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .fifo(fif),
        .o_dc_regs(o_dc_regs),
        .o_channel_sel(o_channel_sel),
        .o_frame_valid(o_frame_valid),
        .o_launch_cmd(o_launch_cmd),
        .o_launch_valid(o_launch_valid),
        .o_err_hdr(o_err_hdr),
        .o_err_timeout(o_err_timeout),
`ifdef DC_ROUTER_CKSUM_EN
        .o_err_cksum(o_err_cksum),
`endif
        .o_frame_cnt(o_frame_cnt),
        .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int fv_cnt = 0, lv_cnt = 0, eh_cnt = 0, et_cnt = 0, ec_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- model ----------------
    function automatic bit hdr_ok(input logic [31:0] w);
        logic [31:0] fld;
        fld = (w >> 8) & ((32'd1 << NCH) - 32'd1);
        return ($countones(fld) == NCH - 1) &&
               ($countones(w >> (NCH + 8)) == 32 - NCH - 8);
    endfunction

    function automatic logic [4:0] hdr_ch(input logic [31:0] w);
        logic [31:0] fld;
        fld = ~(w >> 8) & ((32'd1 << NCH) - 32'd1);
        return 5'($clog2(fld));
    endfunction

    logic [PW-1:0][31:0] m_regs = '0;
    logic [LW-1:0][31:0] m_ln   = '0;
    logic [4:0]  m_ch  = '0;
    logic [4:0]  m_pch = '0;
    logic [15:0] m_cnt = '0;
    bit m_fv, m_lv, m_eh, m_et, m_ec, m_in, m_is_ln;
    int m_gap;
    logic [31:0] m_hdr;
    logic [31:0] m_words[$];

    always begin
        @(posedge clk);
        m_fv = 0; m_lv = 0; m_eh = 0; m_et = 0; m_ec = 0;
        if (rst) begin
            m_regs = '0; m_ln = '0; m_ch = '0; m_cnt = '0;
            m_in = 0; m_gap = 0; m_words.delete();
        end else if (!fe) begin
            m_gap = 0;
            if (!m_in) begin
                if (fd == 32'hFFFF_FFFF) begin
                    m_in = 1; m_is_ln = 1; m_words.delete();
                end else if (hdr_ok(fd)) begin
                    m_in = 1; m_is_ln = 0; m_words.delete();
                    m_pch = hdr_ch(fd); m_hdr = fd;
                end else begin
                    m_eh = 1;
                end
            end else begin
                m_words.push_back(fd);
                if (m_is_ln && m_words.size() == LW) begin
                    for (int i = 0; i < LW; i++) m_ln[i] = m_words[i];
                    m_lv = 1; m_in = 0;
                end else if (!m_is_ln && m_words.size() == PW + CK) begin
                    logic [31:0] x;
                    x = m_hdr;
                    for (int i = 0; i < PW; i++) x ^= m_words[i];
                    if (CK == 0 || m_words[PW + CK - 1] == x) begin
                        for (int i = 0; i < PW; i++) m_regs[i] = m_words[i];
                        m_ch = m_pch; m_cnt++; m_fv = 1;
                    end else begin
                        m_ec = 1;
                    end
                    m_in = 0;
                end
            end
        end else if (m_in) begin
            m_gap++;
            if (m_gap == TO) begin
                m_et = 1; m_in = 0;
            end
        end
        #1;
        chk("fifo_rd", fif.o_fifo_rd, !fe);
        chk("frame_valid", o_frame_valid, m_fv);
        chk("launch_valid", o_launch_valid, m_lv);
        chk("err_hdr", o_err_hdr, m_eh);
        chk("err_timeout", o_err_timeout, m_et);
        chk("busy", o_busy, m_in);
        chk("frame_cnt", o_frame_cnt, m_cnt);
        chk("channel_sel", o_channel_sel, m_ch);
`ifdef DC_ROUTER_CKSUM_EN
        chk("err_cksum", o_err_cksum, m_ec);
        if (o_err_cksum === 1'b1) ec_cnt++;
`endif
        begin
            int bad;
            bad = -1;
            for (int i = PW - 1; i >= 0; i--)
                if (o_dc_regs[i] !== m_regs[i]) bad = i;
            n_chk++;
            if (bad >= 0) begin
                n_fail++;
                $display("FAIL dc_regs[%0d]: got %h expected %h",
                         bad, o_dc_regs[bad], m_regs[bad]);
            end
            bad = -1;
            for (int i = LW - 1; i >= 0; i--)
                if (o_launch_cmd[i] !== m_ln[i]) bad = i;
            n_chk++;
            if (bad >= 0) begin
                n_fail++;
                $display("FAIL launch_cmd[%0d]: got %h expected %h",
                         bad, o_launch_cmd[bad], m_ln[bad]);
            end
        end
        if (o_frame_valid === 1'b1)  fv_cnt++;
        if (o_launch_valid === 1'b1) lv_cnt++;
        if (o_err_hdr === 1'b1)      eh_cnt++;
        if (o_err_timeout === 1'b1)  et_cnt++;
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic [31:0] w);
        @(negedge clk);
        fd = w;
        fe = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            fe = 1'b1;
            fd = 32'h0;
        end
    endtask

    function automatic logic [31:0] pword(input int base, input int step,
                                          input int i, input int ffi);
        return (i == ffi) ? 32'hFFFF_FFFF : 32'(base + step * i);
    endfunction

    task automatic send_frame(input logic [31:0] hdr, input int base,
                              input int step, input int ffi,
                              input bit gaps, input int upto);
`ifdef DC_ROUTER_CKSUM_EN
        logic [31:0] x;
        x = hdr;
`endif
        drive(hdr);
        for (int i = 0; i < upto; i++) begin
`ifdef DC_ROUTER_CKSUM_EN
            x ^= pword(base, step, i, ffi);
`endif
            drive(pword(base, step, i, ffi));
            if (gaps) idle($urandom_range(0, 2));
        end
`ifdef DC_ROUTER_CKSUM_EN
        if (upto == PW) drive(x);
`endif
    endtask

    task automatic send_launch(input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] c, input logic [31:0] e);
        drive(32'hFFFF_FFFF);
        drive(a); drive(b); drive(c); drive(e);
    endtask

    int fv0, lv0, eh0, et0;

    initial begin
        fd = 32'h0; fe = 1'b1; rst = 1'b1;
        idle(3);
        @(negedge clk); rst = 1'b0;
        idle(2);
        chk("rst_frame_cnt", o_frame_cnt, 32'd0);
        chk("rst_busy", o_busy, 32'd0);
        chk("rst_regs0", o_dc_regs[0], 32'd0);
        chk("rst_launch0", o_launch_cmd[0], 32'd0);

        // Channel 4 frame, payload 1..61
        fv0 = fv_cnt;
        send_frame(32'hFFFF_EF00, 1, 1, -1, 0, PW);
        idle(3);
        chk("f1_channel", o_channel_sel, 32'd4);
        chk("f1_regs0", o_dc_regs[0], 32'd1);
        chk("f1_regs60", o_dc_regs[60], 32'd61);
        chk("f1_cnt", o_frame_cnt, 32'd1);
        chk("f1_pulses", fv_cnt - fv0, 32'd1);

        // Launch command
        lv0 = lv_cnt;
        send_launch(32'hA, 32'hB, 32'hC, 32'hD);
        idle(3);
        chk("l1_w0", o_launch_cmd[0], 32'hA);
        chk("l1_w1", o_launch_cmd[1], 32'hB);
        chk("l1_w3", o_launch_cmd[3], 32'hD);
        chk("l1_pulses", lv_cnt - lv0, 32'd1);

        // Invalid headers are dropped
        eh0 = eh_cnt;
        drive(32'hFFFF_0000);
        drive(32'h7FFF_EF00);
        idle(2);
        chk("hdr_err_pulses", eh_cnt - eh0, 32'd2);
        chk("hdr_err_busy", o_busy, 32'd0);
        chk("hdr_err_regs0", o_dc_regs[0], 32'd1);

        // Gappy frame, then back-to-back launch and frame with marker data
        fv0 = fv_cnt; lv0 = lv_cnt;
        send_frame(32'hFEFF_FF00, 100, 1, -1, 1, PW);
        send_launch(32'h11, 32'h22, 32'h33, 32'h44);
        send_frame(32'hFFFF_FE00, 0, 3, 7, 0, PW);
        idle(3);
        chk("b2b_frames", fv_cnt - fv0, 32'd2);
        chk("b2b_launch", lv_cnt - lv0, 32'd1);
        chk("b2b_cnt", o_frame_cnt, 32'd3);
        chk("b2b_channel", o_channel_sel, 32'd0);
        chk("b2b_regs6", o_dc_regs[6], 32'd18);
        chk("b2b_regs7_ff", o_dc_regs[7], 32'hFFFF_FFFF);
        chk("b2b_regs60", o_dc_regs[60], 32'd180);
        chk("b2b_launch3", o_launch_cmd[3], 32'h44);

        // Stall after 10 payload words
        et0 = et_cnt; fv0 = fv_cnt;
        send_frame(32'hFFFF_FD00, 500, 1, -1, 0, 10);
        idle(TO - 3);
        chk("tmo_busy_before", o_busy, 32'd1);
        idle(8);
        chk("tmo_pulses", et_cnt - et0, 32'd1);
        chk("tmo_busy_after", o_busy, 32'd0);
        chk("tmo_regs60", o_dc_regs[60], 32'd180);
        chk("tmo_no_commit", fv_cnt - fv0, 32'd0);
        chk("tmo_cnt", o_frame_cnt, 32'd3);

        // Reset in the middle of a payload
        send_frame(32'hFFFF_EF00, 7, 2, -1, 0, 30);
        @(negedge clk); rst = 1'b1; fe = 1'b1;
        #1;
        chk("arst_busy", o_busy, 32'd0);
        chk("arst_regs60", o_dc_regs[60], 32'd0);
        chk("arst_cnt", o_frame_cnt, 32'd0);
        idle(2);
        @(negedge clk); rst = 1'b0;
        fv0 = fv_cnt;
        send_frame(32'hFFFF_F700, 1000, 1, -1, 0, PW);
        idle(3);
        chk("rst_new_cnt", o_frame_cnt, 32'd1);
        chk("rst_new_pulses", fv_cnt - fv0, 32'd1);
        chk("rst_new_channel", o_channel_sel, 32'd3);
        chk("rst_new_regs0", o_dc_regs[0], 32'd1000);
        chk("rst_new_regs60", o_dc_regs[60], 32'd1060);

`ifdef DC_ROUTER_CKSUM_EN
        begin
            logic [31:0] x;
            int ec0;
            fv0 = fv_cnt; ec0 = ec_cnt;
            x = 32'hFFFF_EF00;
            drive(x);
            for (int i = 0; i < PW; i++) begin
                x ^= 32'(i + 1);
                drive(32'(i + 1));
            end
            drive(x ^ 32'h1);
            idle(3);
            chk("cks_pulses", ec_cnt - ec0, 32'd1);
            chk("cks_no_commit", fv_cnt - fv0, 32'd0);
            chk("cks_regs0", o_dc_regs[0], 32'd1000);
            chk("cks_busy", o_busy, 32'd0);
        end
`endif

        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
